// File: rtl/dco_freq_ctrl_if.sv
// Control/observation bundle between the FLL controller and its host.
// The slave modport is the controller side.
interface dco_freq_ctrl_if #(
    parameter int CNT_W = 16,
    parameter int WIN_W = 24
);
    logic                    enable_i;
    logic                    dco_i;
    logic [WIN_W-1:0]        window_i;
    logic [CNT_W-1:0]        target_i;
    logic [7:0]              freqCode_o;
    logic                    update_o;
    logic signed [CNT_W:0]   err_o;
    logic                    lock_o;

    modport master (
        output enable_i, dco_i, window_i, target_i,
        input  freqCode_o, update_o, err_o, lock_o
    );

    modport slave (
        input  enable_i, dco_i, window_i, target_i,
        output freqCode_o, update_o, err_o, lock_o
    );
endinterface

// File: rtl/dco_freq_ctrl.sv
// Frequency-locked-loop controller: counts DCO edges over a window, compares
// against a target and steps the 8-bit DCO code, flagging lock when stable.
module dco_freq_ctrl #(
    parameter int CNT_W       = 16,
    parameter int WIN_W       = 24,
    parameter int SETTLE_CYC  = 4,
    parameter int LOCK_TOL    = 1,
    parameter int LOCK_N      = 4,
    parameter int COARSE_TH   = 8,
    parameter int COARSE_STEP = 8
) (
    input  logic               internalClock,
    input  logic               reset_i,
    dco_freq_ctrl_if.slave     bus
);
    // state   | meaning
    // IDLE    | loop disabled, code held
    // SETTLE  | waiting SETTLE_CYC clocks for the DCO to settle after a code change
    // MEASURE | counting synchronized DCO rising edges over the window
    // UPDATE  | one cycle: compute error, step code, update lock counter
    typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, UPDATE} state_t;

    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int LCK_W = $clog2(LOCK_N + 1);

    state_t              state_q, state_d;
    logic                sync1_q, sync1_d;
    logic                sync2_q, sync2_d;
    logic                edge_q, edge_d;
    logic [SET_W-1:0]    settle_q, settle_d;
    logic [WIN_W-1:0]    win_q, win_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [7:0]          code_q, code_d;
    logic signed [CNT_W:0] err_q, err_d;
    logic                update_q, update_d;
    logic [LCK_W-1:0]    lock_cnt_q, lock_cnt_d;

    logic                rise;
    logic signed [CNT_W:0] err_calc;
    logic [CNT_W:0]      err_abs;
    logic [7:0]          step;
    logic [8:0]          code_up;

    always_ff @(posedge internalClock or negedge reset_i) begin
        if (!reset_i) begin
            state_q    <= IDLE;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            edge_q     <= 1'b0;
            settle_q   <= '0;
            win_q      <= '0;
            cnt_q      <= '0;
            code_q     <= 8'h7F;
            err_q      <= '0;
            update_q   <= 1'b0;
            lock_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            edge_q     <= edge_d;
            settle_q   <= settle_d;
            win_q      <= win_d;
            cnt_q      <= cnt_d;
            code_q     <= code_d;
            err_q      <= err_d;
            update_q   <= update_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        sync1_d    = bus.dco_i;
        sync2_d    = sync1_q;
        edge_d     = sync2_q;
        settle_d   = settle_q;
        win_d      = win_q;
        cnt_d      = cnt_q;
        code_d     = code_q;
        err_d      = err_q;
        update_d   = 1'b0;
        lock_cnt_d = lock_cnt_q;

        rise     = sync2_q & ~edge_q;
        err_calc = $signed({1'b0, bus.target_i}) - $signed({1'b0, cnt_q});
        err_abs  = err_calc[CNT_W] ? $unsigned(-err_calc) : $unsigned(err_calc);
        step     = (err_abs > (CNT_W+1)'(COARSE_TH)) ? 8'(COARSE_STEP) : 8'd1;
        code_up  = {1'b0, code_q} + {1'b0, step};

        case (state_q)
            IDLE: begin
                if (bus.enable_i) begin
                    state_d  = SETTLE;
                    settle_d = SET_W'(SETTLE_CYC - 1);
                end
            end
            SETTLE: begin
                if (!bus.enable_i) begin
                    state_d    = IDLE;
                    lock_cnt_d = '0;
                end else if (settle_q == '0) begin
                    state_d = MEASURE;
                    cnt_d   = '0;
                    win_d   = (bus.window_i == '0) ? '0 : bus.window_i - WIN_W'(1);
                end else begin
                    settle_d = settle_q - SET_W'(1);
                end
            end
            MEASURE: begin
                if (!bus.enable_i) begin
                    state_d    = IDLE;
                    lock_cnt_d = '0;
                end else begin
                    if (rise && (cnt_q != '1))
                        cnt_d = cnt_q + CNT_W'(1);
                    if (win_q == '0)
                        state_d = UPDATE;
                    else
                        win_d = win_q - WIN_W'(1);
                end
            end
            UPDATE: begin
                err_d    = err_calc;
                update_d = 1'b1;
                if (err_abs <= (CNT_W+1)'(LOCK_TOL)) begin
                    if (lock_cnt_q != LCK_W'(LOCK_N))
                        lock_cnt_d = lock_cnt_q + LCK_W'(1);
                end else begin
                    lock_cnt_d = '0;
                    // positive error means the DCO ran slow, so raise the code
                    if (err_calc[CNT_W])
                        code_d = (code_q < step) ? 8'h00 : code_q - step;
                    else if (err_calc != '0)
                        code_d = code_up[8] ? 8'hFF : code_up[7:0];
                end
                if (bus.enable_i) begin
                    state_d  = SETTLE;
                    settle_d = SET_W'(SETTLE_CYC - 1);
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.freqCode_o = code_q;
    assign bus.update_o   = update_q;
    assign bus.err_o      = err_q;
    assign bus.lock_o     = (lock_cnt_q == LCK_W'(LOCK_N));
endmodule

// File: tb/tb_dco_freq_ctrl.sv
// Directed bench for dco_freq_ctrl with a bench-driven square-wave DCO.
module tb_dco_freq_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dco_freq_ctrl_if #(.CNT_W(16), .WIN_W(24)) bus();

    dco_freq_ctrl dut (
        .internalClock (clk),
        .reset_i       (rst_n),
        .bus           (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int dco_per = 10;

    task automatic check_val(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    function automatic longint err_now();
        longint e;
        e = bus.err_o;
        return e;
    endfunction

    task automatic wait_upd(input int max_cyc, output int n);
        n = 0;
        do begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end while (!bus.update_o && n < max_cyc);
        check_val("update_seen", longint'(bus.update_o), 1);
    endtask

    // square wave: high for the first half of each dco_per-clock period
    initial begin
        int ph = 0;
        bus.dco_i = 1'b0;
        forever begin
            @(negedge clk);
            if (dco_per == 0) begin
                bus.dco_i = 1'b0;
            end else begin
                ph++;
                if (ph >= dco_per) ph = 0;
                bus.dco_i = (ph < dco_per / 2);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int seen;
        longint e;
        longint exp_code;

        bus.enable_i = 1'b1;
        bus.window_i = 24'd100;
        bus.target_i = 16'd10;
        dco_per = 10;

        // reset held with enable high and DCO toggling
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.update_o) seen = 1;
        end
        check_val("rst_code", longint'(bus.freqCode_o), 'h7F);
        check_val("rst_lock", longint'(bus.lock_o), 0);
        check_val("rst_update", longint'(bus.update_o), 0);
        check_val("rst_err", err_now(), 0);
        check_val("rst_no_pulse", seen, 0);

        // in tolerance, lock after 4 updates, 105-clock period
        rst_n = 1'b1;
        wait_upd(300, n);
        check_val("first_latency", n, 106);
        check_val("tol_code_1", longint'(bus.freqCode_o), 'h7F);
        e = err_now();
        check_val("tol_err_1", longint'(e >= -1 && e <= 1), 1);
        check_val("tol_lock_1", longint'(bus.lock_o), 0);
        for (int i = 2; i <= 4; i++) begin
            wait_upd(300, n);
            check_val("tol_spacing", n, 105);
            check_val("tol_code", longint'(bus.freqCode_o), 'h7F);
            e = err_now();
            check_val("tol_err", longint'(e >= -1 && e <= 1), 1);
            check_val("tol_lock", longint'(bus.lock_o), longint'(i == 4));
        end

        // abort 50 clocks into MEASURE
        repeat (4) @(posedge clk);
        repeat (50) @(posedge clk);
        @(negedge clk);
        bus.enable_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_val("abort_lock", longint'(bus.lock_o), 0);
        seen = 0;
        repeat (150) begin
            @(negedge clk);
            if (bus.update_o) seen = 1;
        end
        check_val("abort_no_pulse", seen, 0);
        check_val("abort_code", longint'(bus.freqCode_o), 'h7F);
        bus.enable_i = 1'b1;
        wait_upd(300, n);
        check_val("restart_latency", n, 106);
        repeat (3) wait_upd(300, n);
        check_val("relock", longint'(bus.lock_o), 1);

        // coarse up then fine down
        bus.target_i = 16'd20;
        wait_upd(300, n);
        check_val("coarse_code", longint'(bus.freqCode_o), 'h87);
        check_val("lock_drop", longint'(bus.lock_o), 0);
        e = err_now();
        check_val("coarse_err", longint'(e >= 9 && e <= 11), 1);
        bus.target_i = 16'd5;
        wait_upd(300, n);
        check_val("fine_code_1", longint'(bus.freqCode_o), 'h86);
        e = err_now();
        check_val("fine_err", longint'(e >= -6 && e <= -4), 1);
        wait_upd(300, n);
        check_val("fine_code_2", longint'(bus.freqCode_o), 'h85);

        // reset asserted in the UPDATE cycle
        repeat (104) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_val("upd_rst_code", longint'(bus.freqCode_o), 'h7F);
        check_val("upd_rst_err", err_now(), 0);
        check_val("upd_rst_update", longint'(bus.update_o), 0);
        dco_per = 0;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.update_o) seen = 1;
        end
        check_val("upd_rst_no_pulse", seen, 0);

        // saturation at 0xFF with DCO stopped
        bus.target_i = 16'd20;
        rst_n = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            wait_upd(300, n);
            exp_code = 'h7F + 8 * i;
            if (exp_code > 255) exp_code = 255;
            check_val("sat_hi_code", longint'(bus.freqCode_o), exp_code);
            if (i == 1 || i == 17) check_val("sat_hi_err", err_now(), 20);
        end

        // saturation at 0x00 with DCO far too fast
        dco_per = 2;
        bus.target_i = 16'd0;
        for (int i = 1; i <= 33; i++) begin
            wait_upd(300, n);
            exp_code = 255 - 8 * i;
            if (exp_code < 0) exp_code = 0;
            check_val("sat_lo_code", longint'(bus.freqCode_o), exp_code);
            if (i == 2) check_val("sat_lo_err", err_now(), -50);
        end

        // window of 0 behaves as a 1-clock window
        @(negedge clk);
        rst_n = 1'b0;
        dco_per = 0;
        bus.window_i = 24'd0;
        bus.target_i = 16'd5;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_upd(50, n);
        check_val("win0_latency", n, 7);
        check_val("win0_code", longint'(bus.freqCode_o), 'h80);
        check_val("win0_err", err_now(), 5);
        wait_upd(50, n);
        check_val("win0_spacing", n, 6);
        check_val("win0_code_2", longint'(bus.freqCode_o), 'h81);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
